// File: rtl/lsu_mem_if.sv
// Load/store memory-interface stage: aligns one access at a time onto a word-wide data bus,
// waits for the memory ack (bounded by a timeout) and returns the read data moved to lane 0.
module lsu_mem_if #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_ctrl,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic [2:0]        rsp_ctrl,
   output logic              rsp_err,
   output logic              rsp_misal
);

   // Handshake: an access is taken on the rising edge where req_valid && req_ready are both high;
   // req_ready is high only in IDLE outside reset, and rsp_valid is a single-cycle pulse (no back-pressure).

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_t;

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   state_t            state;
   state_t            state_nxt;

   logic              lat_store;
   logic [2:0]        lat_ctrl;
   logic [ADDR_W-1:0] lat_addr;
   logic [31:0]       lat_wdata;
   logic [CNT_W-1:0]  cnt;

   logic [31:0]       rdata_q;
   logic [2:0]        ctrl_q;
   logic              err_q;
   logic              misal_q;

   logic              accept;
   size_t             req_size;
   size_t             lat_size;
   logic              req_misal;
   logic [1:0]        lane;
   logic [3:0]        be_calc;
   logic [31:0]       wdata_calc;
   logic [31:0]       rd_shift;
   logic [31:0]       rd_lane0;
   logic              timeout_hit;

   logic              load_en;
   logic              cnt_clr;
   logic              cnt_inc;
   logic              resp_load;
   logic [31:0]       resp_rdata_nxt;
   logic [2:0]        resp_ctrl_nxt;
   logic              resp_err_nxt;
   logic              resp_misal_nxt;

   // Codes 101-111 are undefined and behave as a full word.
   function automatic size_t size_of(input logic [2:0] ctrl);
      case (ctrl)
         3'b000, 3'b011: size_of = SZ_BYTE;
         3'b001, 3'b100: size_of = SZ_HALF;
         default:        size_of = SZ_WORD;
      endcase
   endfunction

   assign accept    = req_valid && req_ready;
   assign req_size  = size_of(req_ctrl);
   assign lat_size  = size_of(lat_ctrl);
   assign req_misal = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

   assign lane = lat_addr[1:0];

   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = lat_wdata;
      case (lat_size)
         SZ_BYTE: begin
            be_calc    = 4'b0001 << lane;
            wdata_calc = {4{lat_wdata[7:0]}};
         end
         SZ_HALF: begin
            be_calc    = 4'b0011 << lane;
            wdata_calc = {2{lat_wdata[15:0]}};
         end
         default: begin
            be_calc    = 4'b1111;
            wdata_calc = lat_wdata;
         end
      endcase
   end

   // Read word moved down so the addressed byte sits in lane 0; bits above the access size are cleared.
   assign rd_shift = mem_rdata >> {lane, 3'b000};

   always_comb begin
      rd_lane0 = rd_shift;
      case (lat_size)
         SZ_BYTE: rd_lane0 = {24'd0, rd_shift[7:0]};
         SZ_HALF: rd_lane0 = {16'd0, rd_shift[15:0]};
         default: rd_lane0 = rd_shift;
      endcase
   end

   assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      load_en        = 1'b0;
      cnt_clr        = 1'b0;
      cnt_inc        = 1'b0;
      resp_load      = 1'b0;
      resp_rdata_nxt = 32'd0;
      resp_ctrl_nxt  = lat_ctrl;
      resp_err_nxt   = 1'b0;
      resp_misal_nxt = 1'b0;
      case (state)
         IDLE: begin
            resp_ctrl_nxt = req_ctrl;
            if (accept) begin
               load_en = 1'b1;
               if (req_misal) begin
                  state_nxt      = RESP;
                  resp_load      = 1'b1;
                  resp_err_nxt   = 1'b1;
                  resp_misal_nxt = 1'b1;
               end else begin
                  state_nxt = BUSY;
                  cnt_clr   = 1'b1;
               end
            end
         end
         BUSY: begin
            // An ack in the last allowed cycle still completes the access normally.
            if (mem_ack) begin
               state_nxt      = RESP;
               resp_load      = 1'b1;
               resp_rdata_nxt = lat_store ? 32'd0 : rd_lane0;
            end else if (timeout_hit) begin
               state_nxt    = RESP;
               resp_load    = 1'b1;
               resp_err_nxt = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lat_store <= 1'b0;
         lat_ctrl  <= 3'd0;
         lat_addr  <= '0;
         lat_wdata <= 32'd0;
         cnt       <= '0;
         rdata_q   <= 32'd0;
         ctrl_q    <= 3'd0;
         err_q     <= 1'b0;
         misal_q   <= 1'b0;
      end else begin
         if (load_en) begin
            lat_store <= req_store;
            lat_ctrl  <= req_ctrl;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
         end
         if (cnt_clr) begin
            cnt <= '0;
         end else if (cnt_inc) begin
            cnt <= cnt + 1'b1;
         end
         if (resp_load) begin
            rdata_q <= resp_rdata_nxt;
            ctrl_q  <= resp_ctrl_nxt;
            err_q   <= resp_err_nxt;
            misal_q <= resp_misal_nxt;
         end
      end
   end

   assign req_ready = (state == IDLE) && !rst;

   assign mem_req   = (state == BUSY);
   assign mem_we    = mem_req && lat_store;
   assign mem_addr  = mem_req ? {lat_addr[ADDR_W-1:2], 2'b00} : '0;
   assign mem_be    = mem_req ? be_calc : 4'd0;
   assign mem_wdata = mem_req ? wdata_calc : 32'd0;

   assign rsp_valid = (state == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_ctrl  = ctrl_q;
   assign rsp_err   = rsp_valid && err_q;
   assign rsp_misal = rsp_valid && misal_q;

endmodule
